divmul_unit: RTL and testbench
==============================

// Module: divmul_unit
// PURPOSE
//  Multi-cycle MULT/MULTU/DIV/DIVU engine in the EX stage. It consumes the DivMulEn-qualified
//  instruction held in the ID/EX control register. It raises a stall request that freezes
//  IF..EX until {hi,lo} is ready, then presents the result to the HILO write path.
//  Only one operation is in flight at a time. A flush cancels the operation.
// PARAMETERS
//  MUL_LAT   3   cycles from start accept to result_valid for multiply (>=1, pipelined product)
//  DIV_ITER  32  restoring-division iterations; fixed to operand width
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   asynchronous, active-low reset
//  start        in   1   EX holds a DivMulEn instruction (flush already excluded upstream)
//  op           in   2   divmul_op_t: MULT, MULTU, DIV, DIVU
//  src_a        in   32  rs operand (forwarded)
//  src_b        in   32  rt operand (forwarded)
//  flush        in   1   exception/eret flush of EX; cancels the operation
//  pipe_stall   in   1   stall from other sources (mem etc.); holds DONE
//  stall_req    out  1   combinational stall to the hazard unit
//  result_valid out  1   high while in DONE
//  hi           out  32  HI result (remainder / upper product)
//  lo           out  32  LO result (quotient / lower product)
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, counters=0, result_valid=0; stall_req=0 unless start&IDLE.
//  FSM states: IDLE, MUL, DIV, DONE.
//   IDLE: if start&~flush, latch op/src and go to MUL or DIV; else stay.
//   MUL:  count down MUL_LAT-1..0; at 0 write {hi,lo} and go to DONE.
//   DIV:  one quotient bit per cycle for DIV_ITER cycles, then one sign-fix cycle, then DONE.
//   DONE: stay while pipe_stall; otherwise go to IDLE. The held EX instruction retires that
//         cycle and is never restarted.
//  Latencies, counted as the edge that enters DONE after the accept edge: MUL = MUL_LAT,
//  DIV = DIV_ITER+1 (33).
//  stall_req = (IDLE & start & ~flush) | MUL | DIV. It is 0 in DONE.
//  flush in any state: go to IDLE next edge. hi/lo keep their old values and no
//  result_valid is produced. flush has priority over start and pipe_stall.
//  Arithmetic:
//   - MULT: 64-bit signed product; MULTU: unsigned product. hi=[63:32], lo=[31:0].
//   - DIV/DIVU: divide on magnitudes. Quotient sign = a[31]^b[31]; remainder sign = a[31]
//     (signed only).
//   - 0x8000_0000 / -1 (DIV): lo=0x8000_0000, hi=0 (32-bit wrap, no trap).
//   - Divide by zero, both types: lo=0xFFFF_FFFF, hi=src_a. Still takes 33 cycles.
//  Operands are latched at accept. Later changes on src_a/src_b/op have no effect until IDLE.
//  hi/lo change only on the edge entering DONE and hold until the next completion.
//  Asynchronous reset mid-operation: return to the reset state immediately. No partial
//  result is visible.
// STRUCTURE
//  Shared package:
//   - divmul_op_t enum {DM_MULT, DM_MULTU, DM_DIV, DM_DIVU}
//   - localparam DIV_CYCLES = 33
//   - decoder mapping from alucontrol to op; this mapping lives next to the ctrl_sign fields
//  Sub-module div_radix2: start/busy/done; 32-bit dividend/divisor in; quotient/remainder
//  out, unsigned. The top handles sign pre-processing and post-processing.
//  The multiply pipeline is a MUL_LAT-deep register chain in the top.
// TESTING
//  1. MULT a=0xFFFF_FFFE(-2), b=3 -> stall_req for 3 cycles; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
//  2. MULTU 0xFFFF_FFFF*0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001, valid at edge 3.
//  3. DIV -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF, result_valid at edge 33.
//     DIVU 7/2 -> lo=3, hi=1.
//  4. DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
//     DIVU 5/0 -> lo=0xFFFF_FFFF, hi=5.
//  5. flush at iteration 10 of a DIV -> IDLE next cycle, no valid, hi/lo unchanged.
//     A new start on the following cycle is accepted.
//  6. Completion while pipe_stall=1 for 4 cycles -> DONE held, result_valid=1 throughout,
//     no restart although start is still high. IDLE after stall drops.
//  Also: rst low mid-MUL -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/divmul_unit_pkg.sv
// rtl/divmul_unit_pkg.sv - shared types and op decoding for the mult/div engine
package divmul_unit_pkg;

    typedef enum logic [1:0] {DM_MULT, DM_MULTU, DM_DIV, DM_DIVU} divmul_op_t;
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} divmul_state_t;

    localparam int DATA_W     = 32;
    localparam int DIV_CYCLES = 33;

    typedef struct packed {
        logic is_signed;
        logic is_div;
    } ctrl_sign_t;

    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_DIV   = 4'b1010;
    localparam logic [3:0] ALU_DIVU  = 4'b1011;

    function automatic divmul_op_t decode_divmul_op(input logic [3:0] alucontrol);
        divmul_op_t res;
        case (alucontrol)
            ALU_MULTU: res = DM_MULTU;
            ALU_DIV:   res = DM_DIV;
            ALU_DIVU:  res = DM_DIVU;
            default:   res = DM_MULT;
        endcase
        return res;
    endfunction

    function automatic ctrl_sign_t op_ctrl(input divmul_op_t op);
        ctrl_sign_t res;
        res.is_signed = (op == DM_MULT) || (op == DM_DIV);
        res.is_div    = (op == DM_DIV) || (op == DM_DIVU);
        return res;
    endfunction

endpackage

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - unsigned restoring divider, one quotient bit per cycle
module div_radix2
    import divmul_unit_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);
    localparam int CNT_W = $clog2(ITER + 1);

    logic [DATA_W-1:0] rem_q, quo_q, dsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W:0]   trial, diff;

    // Shift the next dividend bit into the partial remainder and try to subtract.
    assign trial = {rem_q, quo_q[DATA_W-1]};
    assign diff  = trial - {1'b0, dsr_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                rem_q <= '0;
                quo_q <= dividend;
                dsr_q <= divisor;
                cnt_q <= CNT_W'(ITER);
                busy  <= 1'b1;
            end else if (busy) begin
                if (diff[DATA_W]) begin
                    rem_q <= trial[DATA_W-1:0];
                    quo_q <= {quo_q[DATA_W-2:0], 1'b0};
                end else begin
                    rem_q <= diff[DATA_W-1:0];
                    quo_q <= {quo_q[DATA_W-2:0], 1'b1};
                end
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/divmul_unit.sv
// rtl/divmul_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU engine with EX stall request
module divmul_unit
    import divmul_unit_pkg::*;
#(
    parameter int MUL_LAT  = 3,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  divmul_op_t  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        pipe_stall,
    output logic        stall_req,
    output logic        result_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    divmul_state_t state_q, state_d;
    ctrl_sign_t    ctrl_in;
    logic          accept, load_result;
    logic [7:0]    mul_cnt_q;
    logic [63:0]   mul_pipe [MUL_LAT];
    logic [63:0]   a_ext, b_ext, product;
    logic [31:0]   mag_a, mag_b, a_q, quotient, remainder, div_hi, div_lo;
    logic          div_op_q, q_neg_q, r_neg_q, b_zero_q;
    logic          div_busy, div_done;

    assign ctrl_in = op_ctrl(op);
    assign accept  = (state_q == ST_IDLE) && start && !flush;

    // Sign-extending to 64 bits makes the low 64 bits of one multiply serve both flavours.
    assign a_ext   = {{32{ctrl_in.is_signed & src_a[31]}}, src_a};
    assign b_ext   = {{32{ctrl_in.is_signed & src_b[31]}}, src_b};
    assign product = a_ext * b_ext;

    assign mag_a = (ctrl_in.is_signed && src_a[31]) ? -src_a : src_a;
    assign mag_b = (ctrl_in.is_signed && src_b[31]) ? -src_b : src_b;

    div_radix2 #(.ITER(DIV_ITER)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && ctrl_in.is_div),
        .abort     (flush),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    stall_req = 1'b1;
                    state_d   = ctrl_in.is_div ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                stall_req = 1'b1;
                if (mul_cnt_q == 8'd0) state_d = ST_DONE;
            end
            ST_DIV: begin
                stall_req = 1'b1;
                if (div_done && !div_busy) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!pipe_stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_cnt_q <= '0;
            a_q       <= '0;
            div_op_q  <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            b_zero_q  <= 1'b0;
        end else if (accept) begin
            mul_cnt_q <= 8'(MUL_LAT - 1);
            a_q       <= src_a;
            div_op_q  <= ctrl_in.is_div;
            q_neg_q   <= ctrl_in.is_signed && (src_a[31] ^ src_b[31]);
            r_neg_q   <= ctrl_in.is_signed && src_a[31];
            b_zero_q  <= (src_b == 32'd0);
        end else if (state_q == ST_MUL && mul_cnt_q != 8'd0) begin
            mul_cnt_q <= mul_cnt_q - 8'd1;
        end
    end

    // Product chain shifts freely; only the slot captured on the accept edge reaches the end on time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < MUL_LAT; k++) mul_pipe[k] <= '0;
        end else begin
            mul_pipe[0] <= product;
            for (int k = 1; k < MUL_LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
        end
    end

    always_comb begin
        div_lo = q_neg_q ? -quotient : quotient;
        div_hi = r_neg_q ? -remainder : remainder;
        if (b_zero_q) begin
            div_lo = '1;
            div_hi = a_q;
        end
    end

    assign load_result = (state_q == ST_MUL || state_q == ST_DIV) && (state_d == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (load_result) begin
            if (div_op_q) begin
                hi <= div_hi;
                lo <= div_lo;
            end else begin
                {hi, lo} <= mul_pipe[MUL_LAT-1];
            end
        end
    end

    assign result_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_divmul_unit.sv
// tb/tb_divmul_unit.sv - scoreboard bench for divmul_unit
module tb_divmul_unit;
    import divmul_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        pipe_stall = 1'b0;
    divmul_op_t  op = DM_MULT;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        stall_req, result_valid;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    divmul_unit #(.MUL_LAT(3), .DIV_ITER(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .pipe_stall   (pipe_stall),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && result_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("hi", hi, mon_e.hi);
                check("lo", lo, mon_e.lo);
                check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        prev_valid = result_valid;
    end

    task automatic run_op(input divmul_op_t o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int lat, input int hold);
        int n;
        int st;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        e.hi  = eh;
        e.lo  = el;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        #1 check("stall_idle", 32'(stall_req), 32'd1);
        @(negedge clk);
        src_a = 32'hDEAD_BEEF;
        src_b = 32'h0000_0003;
        op    = (o == DM_DIV) ? DM_MULTU : DM_DIVU;
        n  = 0;
        st = 0;
        while (!result_valid && n < 200) begin
            if (stall_req) st++;
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(result_valid), 32'd1);
        check("stall_cycles", 32'(st), 32'(lat));
        check("stall_done", 32'(stall_req), 32'd0);
        pipe_stall = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(result_valid), 32'd1);
            check("hold_stall", 32'(stall_req), 32'd0);
        end
        pipe_stall = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        check("exit_idle", 32'(result_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst = 1'b1;

        run_op(DM_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 3, 0);
        run_op(DM_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3, 0);
        run_op(DM_MULT,  32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, 3, 0);
        run_op(DM_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYCLES, 0);
        run_op(DM_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         DIV_CYCLES, 0);
        run_op(DM_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_CYCLES, 0);
        run_op(DM_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, DIV_CYCLES, 0);
        run_op(DM_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_CYCLES, 0);
        run_op(DM_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_CYCLES, 0);

        @(negedge clk);
        start = 1'b1;
        op    = DM_DIV;
        src_a = 32'd100;
        src_b = 32'd7;
        @(negedge clk);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        check("flush_valid", 32'(result_valid), 32'd0);
        check("flush_stall", 32'(stall_req), 32'd0);
        check("flush_hi", hi, 32'd1);
        check("flush_lo", lo, 32'hFFFF_FFFD);

        run_op(DM_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        DIV_CYCLES, 0);
        run_op(DM_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         3, 4);

        @(negedge clk);
        start = 1'b1;
        op    = DM_MULT;
        src_a = 32'd7;
        src_b = 32'd9;
        @(negedge clk);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("arst_valid", 32'(result_valid), 32'd0);
        check("arst_stall", 32'(stall_req), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_idle", 32'(result_valid), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
